fifo_reader: RTL and testbench



---
 rtl/fifo_reader_if.sv | 42 ++++
 rtl/fifo_reader.sv | 157 +++++++++++++++
 tb/tb_fifo_reader.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_reader_if.sv
// fifo_reader_if: bundles the FIFO pop-side signals and the downstream
// valid/ready stream of the FIFO read controller.
// master = the read controller, slave = the FIFO plus consumer around it.
// Optional macro FIFO_READER_CNT_EN adds the 16-bit dequeue counter words_o.
interface fifo_reader_if #(
   parameter int DW = 8
);
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic          fifo_empty;
   logic          error;
   logic          pop;
   logic          flush_i;
   logic          ready_i;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          busy_o;
   logic          err_o;
`ifdef FIFO_READER_CNT_EN
   logic [15:0]   words_o;

   modport master (
      input  data_out, valid_out, fifo_empty, error, flush_i, ready_i,
      output pop, data_o, valid_o, busy_o, err_o, words_o
   );

   modport slave (
      output data_out, valid_out, fifo_empty, error, flush_i, ready_i,
      input  pop, data_o, valid_o, busy_o, err_o, words_o
   );
`else
   modport master (
      input  data_out, valid_out, fifo_empty, error, flush_i, ready_i,
      output pop, data_o, valid_o, busy_o, err_o
   );

   modport slave (
      output data_out, valid_out, fifo_empty, error, flush_i, ready_i,
      input  pop, data_o, valid_o, busy_o, err_o
   );
`endif
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for a FIFO with 1-cycle read latency.
// Collects words into bursts (flush request or idle timeout), pops under a
// credit rule into a 2-entry output buffer so no word is lost under
// backpressure, and latches a sticky error on FIFO protocol violations.
// Optional macro FIFO_READER_CNT_EN adds words_o, a wrapping 16-bit count of
// delivered words that freezes once an error has been flagged.
module fifo_reader #(
   parameter int DW      = 8,
   parameter int AW      = 3,
   parameter int IDLE_TO = 6
) (
   input logic           clk,
   input logic           reset,
   fifo_reader_if.master bus
);

   localparam int CW = $clog2(IDLE_TO);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_ERR   = 2'd2;

   if (IDLE_TO < 2 || AW < 1) begin : gBadParams
      $error("fifo_reader: IDLE_TO must be >= 2 and AW >= 1");
   end

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] idleCnt_q, idleCnt_d;
   logic          inflight_q;
   logic          err_q;
   logic [DW-1:0] buf0_q, buf1_q;
   logic          rdPtr_q;
   logic [1:0]    occ_q;

   logic          validOut;
   logic          deq;
   logic [2:0]    committed;
   logic          room;
   logic          popC;
   logic          overflow;
   logic          protoErr;
   logic          bufWr;
   logic          wrPtr;
   logic [CW-1:0] idleCntInc;

   // Buffer status, credit check and pop decision. Words already buffered plus
   // the one possibly in flight must leave a free slot after this cycle's
   // dequeue, so the returning word always has somewhere to land.
   always_comb begin
      validOut   = (occ_q != 2'd0);
      deq        = validOut && bus.ready_i;
      committed  = 3'(occ_q) + 3'(inflight_q) - 3'(deq);
      room       = (committed < 3'd2);
      popC       = (state_q == ST_DRAIN) && !bus.fifo_empty && room && !err_q;
      overflow   = bus.valid_out && (occ_q == 2'd2) && !deq;
      protoErr   = bus.error || (bus.valid_out && !inflight_q) || overflow;
      bufWr      = bus.valid_out && !overflow;
      wrPtr      = rdPtr_q ^ occ_q[0];
      idleCntInc = idleCnt_q + CW'(1);
   end

   // Burst scheduling. In IDLE a non-empty FIFO ages the counter; the drain
   // starts on the cycle the counter would reach IDLE_TO-1, so the first pop
   // lands on the IDLE_TO-th cycle after the FIFO became non-empty.
   always_comb begin
      state_d   = state_q;
      idleCnt_d = idleCnt_q;
      if (protoErr || state_q == ST_ERR) begin
         state_d   = ST_ERR;
         idleCnt_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.fifo_empty) begin
                  idleCnt_d = '0;
               end else begin
                  idleCnt_d = idleCntInc;
               end
               if (bus.flush_i || (!bus.fifo_empty && idleCntInc == CW'(IDLE_TO - 1))) begin
                  state_d   = ST_DRAIN;
                  idleCnt_d = '0;
               end
            end
            ST_DRAIN: begin
               idleCnt_d = '0;
               if (bus.fifo_empty && !inflight_q && !bus.flush_i) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d   = ST_ERR;
               idleCnt_d = '0;
            end
         endcase
      end
   end

   // Control state: FSM, idle counter, outstanding-pop flag and sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         idleCnt_q  <= '0;
         inflight_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idleCnt_q  <= idleCnt_d;
         inflight_q <= popC;
         err_q      <= err_q | protoErr;
      end
   end

   // Two-entry output buffer: returning FIFO words are appended at the tail,
   // the consumer takes the head; both may happen in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf0_q  <= '0;
         buf1_q  <= '0;
         rdPtr_q <= 1'b0;
         occ_q   <= 2'd0;
      end else begin
         if (bufWr) begin
            if (wrPtr) begin
               buf1_q <= bus.data_out;
            end else begin
               buf0_q <= bus.data_out;
            end
         end
         if (deq) begin
            rdPtr_q <= ~rdPtr_q;
         end
         occ_q <= occ_q + 2'(bufWr) - 2'(deq);
      end
   end

`ifdef FIFO_READER_CNT_EN
   logic [15:0] words_q;

   // Delivered-word counter; wraps naturally and freezes after an error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         words_q <= '0;
      end else if (deq && !err_q) begin
         words_q <= words_q + 16'd1;
      end
   end

   assign bus.words_o = words_q;
`endif

   assign bus.pop     = popC;
   assign bus.data_o  = rdPtr_q ? buf1_q : buf0_q;
   assign bus.valid_o = validOut;
   assign bus.busy_o  = (state_q == ST_DRAIN);
   assign bus.err_o   = err_q;

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed bench for fifo_reader. A queue-based FIFO stands
// in for the real FIFO, a queue-based reference model predicts every output
// each cycle, and a few literal expectations pin the model to known numbers.
module tb_fifo_reader;

   localparam int DW      = 8;
   localparam int IDLE_TO = 6;

   typedef enum {M_IDLE, M_DRAIN, M_ERR} mode_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   fifo_reader_if #(.DW(DW)) bus ();

   fifo_reader #(.DW(DW), .AW(3), .IDLE_TO(IDLE_TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   bit [7:0] fifoQ[$];
   bit [7:0] outQ[$];
   int       popCount;
   int       busyCount;
   int       firstPopCyc;
   int       lastPopCyc;
   int       cyc = 0;
   int       deqTotal;
   int       emptyPopCount;
   bit       autoFill;
   bit [7:0] fillVal;

   bit [7:0] mBuf[$];
   bit       mInfl;
   bit       mErr;
   mode_t    mMode;
   int       mWait;
   int       mWords;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkSeq(input string name, input int base, input int n);
      checkOutput({name, "_count"}, outQ.size(), n);
      for (int i = 0; i < n && i < outQ.size(); i++) begin
         checkOutput($sformatf("%s_word%0d", name, i), outQ[i], 32'((base + i) & 8'hFF));
      end
   endtask

   // Compare process: check every output against the model, record what the
   // DUT actually did, then advance the model by one clock.
   always @(negedge clk) begin
      bit expPop;
      bit expValid;
      bit deq;
      bit errNow;
      bit leaveDrain;
      if (!reset) begin
         mBuf.delete();
         mInfl  = 1'b0;
         mErr   = 1'b0;
         mMode  = M_IDLE;
         mWait  = 0;
         mWords = 0;
         checkOutput("rst_pop", bus.pop, 0);
         checkOutput("rst_valid_o", bus.valid_o, 0);
         checkOutput("rst_data_o", bus.data_o, 0);
         checkOutput("rst_busy_o", bus.busy_o, 0);
         checkOutput("rst_err_o", bus.err_o, 0);
      end else begin
         expValid = (mBuf.size() != 0);
         deq      = expValid && bus.ready_i;
         expPop   = (mMode == M_DRAIN) && !bus.fifo_empty && !mErr &&
                    ((mBuf.size() + int'(mInfl) - int'(deq)) < 2);
         checkOutput("pop", bus.pop, expPop);
         checkOutput("valid_o", bus.valid_o, expValid);
         checkOutput("busy_o", bus.busy_o, mMode == M_DRAIN);
         checkOutput("err_o", bus.err_o, mErr);
         if (expValid) checkOutput("data_o", bus.data_o, mBuf[0]);
`ifdef FIFO_READER_CNT_EN
         checkOutput("words_o", bus.words_o, mWords);
`endif
         if (bus.pop) begin
            popCount++;
            if (firstPopCyc < 0) firstPopCyc = cyc;
            lastPopCyc = cyc;
         end
         if (bus.busy_o) busyCount++;
         if (bus.valid_o && bus.ready_i) begin
            outQ.push_back(bus.data_o);
            deqTotal++;
         end

         errNow     = bus.error || (bus.valid_out && !mInfl) ||
                      (bus.valid_out && mBuf.size() == 2 && !deq);
         leaveDrain = (mMode == M_DRAIN) && bus.fifo_empty && !mInfl && !bus.flush_i;
         if (deq) begin
            void'(mBuf.pop_front());
            if (!mErr) mWords = (mWords + 1) & 32'hFFFF;
         end
         if (bus.valid_out && mBuf.size() < 2) mBuf.push_back(bus.data_out);
         if (errNow || mMode == M_ERR) begin
            mMode = M_ERR;
            mErr  = 1'b1;
         end else if (mMode == M_IDLE) begin
            mWait = bus.fifo_empty ? 0 : mWait + 1;
            if (bus.flush_i || (!bus.fifo_empty && mWait == IDLE_TO - 1)) begin
               mMode = M_DRAIN;
               mWait = 0;
            end
         end else if (leaveDrain) begin
            mMode = M_IDLE;
         end
         mInfl = expPop;
         cyc++;
      end
   end

   // Advance n clocks, acting as the FIFO: a pop seen before the edge returns
   // the head word one cycle later and updates the empty flag after the edge.
   task automatic applyStimulus(input int n);
      bit p;
      repeat (n) begin
         @(negedge clk);
         p = bus.pop;
         if (p && fifoQ.size() == 0) emptyPopCount++;
         @(posedge clk);
         #1;
         if (p && fifoQ.size() > 0) begin
            bus.valid_out = 1'b1;
            bus.data_out  = fifoQ.pop_front();
         end else begin
            bus.valid_out = 1'b0;
         end
         if (autoFill && fifoQ.size() < 4) begin
            fifoQ.push_back(fillVal);
            fillVal++;
         end
         bus.fifo_empty = (fifoQ.size() == 0);
      end
   endtask

   task automatic preload(input int base, input int n);
      for (int i = 0; i < n; i++) fifoQ.push_back(8'((base + i) & 8'hFF));
      bus.fifo_empty = (fifoQ.size() == 0);
   endtask

   task automatic clearStats();
      outQ.delete();
      popCount      = 0;
      busyCount     = 0;
      firstPopCyc   = -1;
      lastPopCyc    = -1;
      deqTotal      = 0;
      emptyPopCount = 0;
   endtask

   // Asynchronous reset: outputs must be at reset values without any clock.
   task automatic doReset(input string tag);
      reset = 1'b0;
      #1;
      checkOutput({tag, "_pop"}, bus.pop, 0);
      checkOutput({tag, "_valid_o"}, bus.valid_o, 0);
      checkOutput({tag, "_data_o"}, bus.data_o, 0);
      checkOutput({tag, "_busy_o"}, bus.busy_o, 0);
      checkOutput({tag, "_err_o"}, bus.err_o, 0);
`ifdef FIFO_READER_CNT_EN
      checkOutput({tag, "_words_o"}, bus.words_o, 0);
`endif
      fifoQ.delete();
      autoFill       = 1'b0;
      bus.data_out   = '0;
      bus.valid_out  = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.error      = 1'b0;
      bus.flush_i    = 1'b0;
      bus.ready_i    = 1'b1;
      applyStimulus(2);
      reset = 1'b1;
      applyStimulus(1);
      clearStats();
   endtask

   initial begin
      int startCyc;
      int popsBefore;
      bus.data_out   = '0;
      bus.valid_out  = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.error      = 1'b0;
      bus.flush_i    = 1'b0;
      bus.ready_i    = 1'b1;
      fillVal        = 8'h00;
      clearStats();
      #2;
      doReset("por");

      // Idle timeout: three words, no flush.
      preload(8'hA1, 3);
      startCyc = cyc;
      applyStimulus(12);
      checkOutput("to_first_pop_cycle", firstPopCyc - startCyc + 1, 6);
      checkOutput("to_pop_count", popCount, 3);
      checkOutput("to_pops_consecutive", lastPopCyc - firstPopCyc, 2);
      checkSeq("to_out", 8'hA1, 3);
      checkOutput("to_back_idle", bus.busy_o, 0);

      // Flushed burst of eight with the consumer always ready.
      doReset("r2");
      preload(8'h20, 8);
      bus.flush_i = 1'b1;
      applyStimulus(1);
      bus.flush_i = 1'b0;
      applyStimulus(14);
      checkOutput("fl_pop_count", popCount, 8);
      checkOutput("fl_pops_consecutive", lastPopCyc - firstPopCyc, 7);
      checkOutput("fl_busy_len_9_10", (busyCount >= 9 && busyCount <= 10), 1);
      checkOutput("fl_busy_end", bus.busy_o, 0);
      checkSeq("fl_out", 8'h20, 8);

      // Backpressure: only two credits while the consumer stalls.
      doReset("r3");
      bus.ready_i = 1'b0;
      preload(8'h30, 8);
      bus.flush_i = 1'b1;
      applyStimulus(1);
      bus.flush_i = 1'b0;
      applyStimulus(8);
      checkOutput("bp_pop_count", popCount, 2);
      checkOutput("bp_valid_held", bus.valid_o, 1);
      checkOutput("bp_head", bus.data_o, 8'h30);
      checkOutput("bp_no_pop", bus.pop, 0);
      bus.ready_i = 1'b1;
      applyStimulus(14);
      checkOutput("bp_pop_total", popCount, 8);
      checkSeq("bp_out", 8'h30, 8);

      // Consumer toggling ready every cycle.
      doReset("r4");
      preload(8'h10, 8);
      bus.flush_i = 1'b1;
      applyStimulus(1);
      bus.flush_i = 1'b0;
      for (int i = 0; i < 30; i++) begin
         bus.ready_i = (i % 2 == 0);
         applyStimulus(1);
      end
      bus.ready_i = 1'b1;
      applyStimulus(5);
      checkSeq("tg_out", 8'h10, 8);
      checkOutput("tg_pop_while_empty", emptyPopCount, 0);

      // FIFO error mid-burst with one word buffered.
      doReset("r5");
      bus.ready_i = 1'b0;
      bus.flush_i = 1'b1;
      preload(8'h5A, 1);
      applyStimulus(3);
      checkOutput("er_one_buffered", bus.valid_o, 1);
      preload(8'h5B, 3);
      bus.error = 1'b1;
      applyStimulus(1);
      bus.error   = 1'b0;
      bus.flush_i = 1'b0;
      checkOutput("er_err_o_set", bus.err_o, 1);
      bus.ready_i = 1'b1;
      popsBefore  = popCount;
      applyStimulus(10);
      checkOutput("er_no_more_pops", popCount - popsBefore, 0);
      checkOutput("er_err_sticky", bus.err_o, 1);
      checkSeq("er_out", 8'h5A, 2);
      doReset("er_rst");

`ifdef FIFO_READER_CNT_EN
      // 0x10000 deliveries wrap the counter to zero, then reset mid-drain.
      autoFill    = 1'b1;
      fillVal     = 8'h00;
      bus.flush_i = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         applyStimulus(1);
         if (deqTotal == 65536) break;
      end
      checkOutput("cnt_deq_total", deqTotal, 65536);
      checkOutput("cnt_wrapped", bus.words_o, 0);
      applyStimulus(3);
      checkOutput("cnt_counting", bus.words_o, 3);
      doReset("cnt_rst");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_500_000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
